// File: rtl/dcache_wb_param.sv
// Two-way set-associative write-back data cache with one LRU bit per set and a halt-triggered flush.
// Misses write back a dirty victim word by word, then refill the line; dwait stalls each word transfer.
module dcache_wb_param #(
    parameter int SETS      = 8,
    parameter int BLK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int WAYS      = 2;
    localparam int WOFF_BITS = $clog2(BLK_WORDS);
    localparam int WOFF_W    = (WOFF_BITS > 0) ? WOFF_BITS : 1;
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_LSB   = 2 + WOFF_BITS + IDX_W;
    localparam int TAG_W     = 32 - TAG_LSB;

    localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(BLK_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_SET  = IDX_W'(SETS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FLUSH_SCAN,
        FLUSH_WB,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WOFF_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  set_q, set_d;
    logic              way_q, way_d;
    logic [TAG_W-1:0]  mtag_q, mtag_d;

    logic [31:0]       data_q  [WAYS][SETS][BLK_WORDS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   dirty_q [WAYS];
    logic [SETS-1:0]   lru_q;

    logic [WOFF_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit0, hit1, hit_way;
    logic              victim_way, victim_dirty;
    logic              pair_last;
    logic              hit_upd, miss_go, fill_we, fill_done, flush_clr;
    logic              unused_addr_bits;

    // Request address fields; the byte offset never selects anything.
    assign req_word = (BLK_WORDS > 1) ? dmemaddr[2 +: WOFF_W] : '0;
    assign req_idx  = dmemaddr[2 + WOFF_BITS +: IDX_W];
    assign req_tag  = dmemaddr[31 -: TAG_W];
    assign unused_addr_bits = ^dmemaddr[1:0];

    function automatic logic [31:0] make_addr(input logic [TAG_W-1:0]  t,
                                              input logic [IDX_W-1:0]  s,
                                              input logic [WOFF_W-1:0] w);
        logic [31:0] a;
        a = '0;
        a[31 -: TAG_W]          = t;
        a[2 + WOFF_BITS +: IDX_W] = s;
        if (BLK_WORDS > 1) a[2 +: WOFF_W] = w;
        return a;
    endfunction

    assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit_way = hit1;

    // Invalid ways are filled first (way 0 preferred); otherwise the LRU bit names the victim.
    assign victim_way   = !valid_q[0][req_idx] ? 1'b0 :
                          !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];

    assign pair_last = way_q && (set_q == LAST_SET);
    assign flushed   = (state_q == DONE);
    assign dmemload  = dhit ? data_q[hit_way][req_idx][req_word] : 32'hBADB_EEF1;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        word_d    = word_q;
        set_d     = set_q;
        way_d     = way_q;
        mtag_d    = mtag_q;
        dhit      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        hit_upd   = 1'b0;
        miss_go   = 1'b0;
        fill_we   = 1'b0;
        fill_done = 1'b0;
        flush_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH_SCAN;
                    set_d   = '0;
                    way_d   = 1'b0;
                    word_d  = '0;
                end else if (dmemREN || dmemWEN) begin
                    if (hit0 || hit1) begin
                        dhit    = 1'b1;
                        hit_upd = 1'b1;
                    end else begin
                        miss_go = 1'b1;
                        set_d   = req_idx;
                        way_d   = victim_way;
                        mtag_d  = req_tag;
                        word_d  = '0;
                        state_d = victim_dirty ? WB : FETCH;
                    end
                end
            end

            WB, FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = make_addr(tag_q[way_q][set_q], set_q, word_q);
                dstore = data_q[way_q][set_q][word_q];
                if (!dwait) begin
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (state_q == WB) begin
                            state_d = FETCH;
                        end else begin
                            flush_clr = 1'b1;
                            if (pair_last) begin
                                state_d = DONE;
                            end else begin
                                state_d = FLUSH_SCAN;
                                way_d   = ~way_q;
                                if (way_q) set_d = set_q + 1'b1;
                            end
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end

            FETCH: begin
                dREN  = 1'b1;
                daddr = make_addr(mtag_q, set_q, word_q);
                if (!dwait) begin
                    fill_we = 1'b1;
                    if (word_q == LAST_WORD) begin
                        fill_done = 1'b1;
                        word_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end

            FLUSH_SCAN: begin
                if (valid_q[way_q][set_q] && dirty_q[way_q][set_q]) begin
                    state_d = FLUSH_WB;
                    word_d  = '0;
                end else if (pair_last) begin
                    state_d = DONE;
                end else begin
                    way_d = ~way_q;
                    if (way_q) set_d = set_q + 1'b1;
                end
            end

            DONE: state_d = DONE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            word_q  <= '0;
            set_q   <= '0;
            way_q   <= 1'b0;
            mtag_q  <= '0;
            lru_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            set_q   <= set_d;
            way_q   <= way_d;
            mtag_q  <= mtag_d;
            if (hit_upd) begin
                lru_q[req_idx] <= ~hit_way;
                if (dmemWEN) dirty_q[hit_way][req_idx] <= 1'b1;
            end
            // The victim stays invalid until its refill completes, so an aborted fill never hits.
            if (miss_go) valid_q[victim_way][req_idx] <= 1'b0;
            if (fill_done) begin
                valid_q[way_q][set_q] <= 1'b1;
                dirty_q[way_q][set_q] <= 1'b0;
            end
            if (flush_clr) dirty_q[way_q][set_q] <= 1'b0;
        end
    end

    // NOTE: data and tag storage is not reset; the valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (hit_upd && dmemWEN) data_q[hit_way][req_idx][req_word] <= dmemstore;
        if (fill_we)            data_q[way_q][set_q][word_q]        <= dload;
        if (fill_done)          tag_q[way_q][set_q]                 <= mtag_q;
    end

endmodule

// File: doc/dcache_wb_param.md
DCACHE_WB_PARAM -- requirements
Module: dcache_wb_param

Interface
REQ-001 Parameter SETS, default 8: number of sets; power of two, 2..64.
REQ-002 Parameter BLK_WORDS, default 2: 32-bit words per block; power of two, 1..8.
REQ-003 Parameter WAYS is fixed at 2: two-way set associative, one LRU bit per set.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 nRST  in  1  reset, asynchronous and active-low.
REQ-006 dmemREN  in  1  datapath read request.
REQ-007 dmemWEN  in  1  datapath write request; never asserted together with dmemREN.
REQ-008 dmemaddr  in  32  byte address; bits [1:0] are ignored.
REQ-009 dmemstore  in  32  write data.
REQ-010 halt  in  1  requests a full flush; level-sensitive.
REQ-011 dhit  out  1  request satisfied this cycle.
REQ-012 dmemload  out  32  read data, valid when dhit=1 on a read.
REQ-013 flushed  out  1  all dirty lines have been written back.
REQ-014 dREN  out  1  memory read strobe.
REQ-015 dWEN  out  1  memory write strobe.
REQ-016 daddr  out  32  memory word address, bits [1:0] always 0.
REQ-017 dstore  out  32  memory write data.
REQ-018 dload  in  32  memory read data, valid when dwait=0.
REQ-019 dwait  in  1  memory busy; a word transfer completes on a cycle with dREN or dWEN high and dwait=0.

Function
REQ-020 Address split, from LSB: byte offset 2 bits, word offset log2(BLK_WORDS) bits, index log2(SETS) bits; the remaining upper bits are the tag.
REQ-021 Each line holds valid, dirty, tag and BLK_WORDS data words.
REQ-022 States: IDLE, WB, FETCH, FLUSH_SCAN, FLUSH_WB, DONE.
REQ-023 In IDLE, a hit is: (dmemREN or dmemWEN) and way valid and tag match, with halt=0.
REQ-024 On a hit, dhit=1 combinationally in the same cycle.
REQ-025 On a read hit, dmemload shall equal the addressed word.
REQ-026 On a write hit, dmemstore is written to the addressed word at the clock edge and dirty is set to 1.
REQ-027 On every hit, the set's LRU bit is set to point at the other way.
REQ-028 When dhit=0, dmemload shall be 32'hBADBEEF1.
REQ-029 Victim selection on a miss: the first invalid way (way 0 preferred); otherwise the way named by the LRU bit.
REQ-030 Miss with a valid, dirty victim: IDLE->WB.
  - Words w=0..BLK_WORDS-1 in order: dWEN=1, daddr={victim tag, index, w, 2'b00}, dstore=victim word w.
  - The word counter advances on dwait=0; after the last word, WB->FETCH.
REQ-031 Miss with a clean or invalid victim: IDLE->FETCH directly.
REQ-032 FETCH, words w=0..BLK_WORDS-1 in order: dREN=1, daddr={req tag, index, w, 2'b00}; dload is captured into word w on dwait=0.
REQ-033 After the last fetched word:
  - the line gets valid=1, dirty=0 and the request tag;
  - state returns to IDLE, and the retried request hits on the next cycle.
REQ-034 The line's valid bit stays 0 throughout FETCH.
REQ-035 dREN and dWEN shall never both be 1; both are 0 in IDLE and DONE.
REQ-036 Requests that drop mid-miss do not abort WB or FETCH; the transfer completes.
REQ-037 halt=1 in IDLE takes priority over any request: IDLE->FLUSH_SCAN and dhit=0.
REQ-038 halt is sampled only in IDLE; a halt raised mid-miss is honoured after the return to IDLE.
REQ-039 FLUSH_SCAN visits (set, way) pairs in order set 0 way 0, set 0 way 1, set 1 way 0, ..., one pair per cycle.
  - A valid, dirty pair moves to FLUSH_WB, which writes back its words as in REQ-030, clears dirty, and resumes the scan at the next pair.
REQ-040 After the last pair the state moves to DONE: flushed=1, dhit=0, and the block ignores all inputs until reset.
REQ-041 Every counter wraps only at its terminal value; there are no out-of-range index or word accesses.

Reset
REQ-042 nRST=0 forces, immediately:
  - state IDLE; all valid, dirty and LRU bits 0; counters 0;
  - dREN, dWEN, flushed and dhit 0; daddr and dstore 0.
REQ-043 Reset asserted during WB, FETCH or flush aborts the operation; the partially transferred line is left invalid.

Verification
REQ-044 Cold read of 0x0000_0040 with dload=0x1111_0000 then 0x1111_0004, dwait=0:
  - daddr 0x40 then 0x44 with dREN=1;
  - then dhit=1 and dmemload=0x1111_0000.
REQ-045 Write hit of 0xCAFE_F00D to 0x44 after REQ-044: dhit=1 that cycle; a following read of 0x44 returns 0xCAFE_F00D.
REQ-046 Conflict sequence at set 0:
  - steps: dirty line 0x44, then a miss fill of 0x240 into the other way, then a read of 0x440;
  - required: the LRU victim is written back first (two dWEN cycles), then 0x440 is fetched.
REQ-047 dwait held high for 3 cycles per word during WB: daddr and dstore hold steady, and no word is skipped or repeated.
REQ-048 halt with two dirty lines, in sets 0 and 5: exactly 2*BLK_WORDS dWEN transfers in scan order, then flushed=1 and it stays high.
REQ-049 nRST pulsed mid-FETCH: all outputs reach 0 asynchronously; the next access to the same address misses and refetches.
